imem_mp: RTL and testbench
==========================

Name: imem_mp

Overview:
- Parametrised instruction/data memory with one instruction fetch port and NUM_DPORTS independent data read ports.
- Adds a boot-load stream port, so firmware is loaded at run time rather than preinitialised from a file.
- All reads are synchronous posedge, 1-cycle latency, with explicit request/valid.
- Sits between the fetch stage, the load/store units and the host/UART bootloader.

Parameters:
- IMEM_DEPTH, 14: address width in words; ENTRIES = 2**IMEM_DEPTH.
- MEM_W, 32: stored word width.
- INST_W, 32: instruction output width, INST_W <= MEM_W; the low INST_W bits of the word are returned.
- NUM_DPORTS, 2: number of data read ports, 1..4.

Ports:
- clk, in, 1: clock; all state updates on posedge.
- rst_n, in, 1: asynchronous active-low reset.
- load_valid_i, in, 1: boot-load beat valid.
- load_ready_o, out, 1: boot-load beat accepted when valid & ready.
- load_data_i, in, MEM_W: boot-load word.
- load_last_i, in, 1: final beat of the image.
- reload_i, in, 1: request a return to the LOAD state.
- boot_done_o, out, 1: high in RUN.
- words_loaded_o, out, IMEM_DEPTH+1: beats accepted in the current or most recent load.
- inst_req_i, in, 1: fetch request.
- inst_addr_i, in, IMEM_DEPTH: fetch word address.
- inst_valid_o, out, 1: fetch data valid.
- inst_o, out, INST_W: fetched instruction.
- data_req_i, in, NUM_DPORTS: per-port read request.
- data_addr_i, in, NUM_DPORTS*IMEM_DEPTH: packed addresses; port k occupies bits [k*IMEM_DEPTH +: IMEM_DEPTH].
- data_valid_o, out, NUM_DPORTS: per-port data valid.
- data_o, out, NUM_DPORTS*MEM_W: packed read data.

Behaviour:
- States: LOAD, RUN.
  - load_ready_o = (state==LOAD).
  - boot_done_o = (state==RUN).
- Reset (async assert) sets:
  - state=LOAD, cnt=0, words_loaded_o=0;
  - all valid outputs 0; inst_o=0; data_o=0.
  - Memory array contents are not reset.
- LOAD, on each accepted beat:
  - mem[cnt] <= load_data_i; cnt <= cnt+1; words_loaded_o <= cnt+1.
- LOAD -> RUN:
  - on an accepted beat with load_last_i=1, or on the accepted beat where cnt==ENTRIES-1 (array full).
  - That beat is still written.
  - Beats with valid=0 change nothing.
- Full-array load: words_loaded_o == ENTRIES (hence width IMEM_DEPTH+1); no wrap, no overwrite of word 0.
- Reads while in LOAD: inst_req_i and data_req_i are ignored; valids stay 0 and outputs hold.
- RUN, reads:
  - inst_req_i=1 at edge N gives inst_valid_o=1 and inst_o=mem[inst_addr_i][INST_W-1:0] after edge N.
  - Data port k behaves identically and independently.
  - Valids are single-cycle pulses per request; back-to-back requests give back-to-back valids.
  - Data outputs hold their last value when not requested.
- Any number of ports may read the same or different addresses in the same cycle; there are no stalls or conflicts.
- RUN -> LOAD:
  - reload_i=1 in RUN moves to LOAD next cycle with cnt=0.
  - A read requested in that same cycle still completes (valid next cycle).
  - words_loaded_o keeps its old value until the first accepted beat.
  - reload_i in LOAD is ignored.
- Reset mid-load: restart from cnt=0; already-written words persist until overwritten.
- No write path exists in RUN; the array is read-only to the core.

Test Plan:
- Reset, then 4 beats 0x11,0x22,0x33,0x44 with last on beat 4 -> load_ready_o=1 throughout, boot_done_o=1 the cycle after beat 4, words_loaded_o=4.
- After that load, inst_req addr 2 plus data_req port0 addr 0 and port1 addr 3 in one cycle -> next cycle all valids 1, inst_o=0x33, data0=0x11, data1=0x44; idle next cycle -> valids 0, data held.
- Gapped load (valid toggling), and a read request during LOAD -> only valid beats written, no read valid asserted.
- IMEM_DEPTH=3, 8 beats with no last -> RUN after beat 8, words_loaded_o=8, mem[0] intact.
- In RUN: reload_i plus inst_req same cycle -> inst_valid_o next cycle, then LOAD; new 2-beat image 0xA0,0xB0 -> mem[0]=0xA0, mem[2] still 0x33.
- rst_n low mid-load after beat 2 -> state LOAD, cnt 0, words_loaded_o=0, outputs 0; reload resumes at address 0.

Source files
------------

// File: rtl/imem_mp.sv
// imem_mp: boot-loadable instruction/data memory with one fetch port and NUM_DPORTS read ports.
// Firmware streams in while in LOAD; the array is read-only once RUN is reached.
module imem_mp #(
  parameter int IMEM_DEPTH = 14,
  parameter int MEM_W      = 32,
  parameter int INST_W     = 32,
  parameter int NUM_DPORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_valid_i,
  output logic                             load_ready_o,
  input  logic [MEM_W-1:0]                 load_data_i,
  input  logic                             load_last_i,
  input  logic                             reload_i,
  output logic                             boot_done_o,
  output logic [IMEM_DEPTH:0]              words_loaded_o,
  input  logic                             inst_req_i,
  input  logic [IMEM_DEPTH-1:0]            inst_addr_i,
  output logic                             inst_valid_o,
  output logic [INST_W-1:0]                inst_o,
  input  logic [NUM_DPORTS-1:0]            data_req_i,
  input  logic [NUM_DPORTS*IMEM_DEPTH-1:0] data_addr_i,
  output logic [NUM_DPORTS-1:0]            data_valid_o,
  output logic [NUM_DPORTS*MEM_W-1:0]      data_o
);
  localparam int ENTRIES = 2**IMEM_DEPTH;
  localparam logic [0:0] LOAD = 1'b0, RUN = 1'b1;
  logic [MEM_W-1:0] mem [ENTRIES];
  logic [0:0] state_q, state_d;
  logic [IMEM_DEPTH-1:0] cnt_q, cnt_d;
  logic [IMEM_DEPTH:0] words_q, words_d, cnt_inc;
  logic inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [NUM_DPORTS-1:0] dvalid_q, dvalid_d;
  logic [NUM_DPORTS*MEM_W-1:0] data_q, data_d;
  logic run, accept;

  assign run     = state_q == RUN;
  assign accept  = load_valid_i & ~run;
  // widened so a full-array load reports ENTRIES instead of wrapping to 0
  assign cnt_inc = {1'b0, cnt_q} + (IMEM_DEPTH+1)'(1);

  always_comb begin
    state_d      = run ? (reload_i ? LOAD : RUN) : ((accept && (load_last_i || &cnt_q)) ? RUN : LOAD);
    cnt_d        = accept ? cnt_inc[IMEM_DEPTH-1:0] : ((run && reload_i) ? '0 : cnt_q);
    words_d      = accept ? cnt_inc : words_q;
    inst_valid_d = run & inst_req_i;
    inst_d       = inst_valid_d ? mem[inst_addr_i][INST_W-1:0] : inst_q;
    dvalid_d     = run ? data_req_i : '0;
    data_d       = data_q;
    for (int k = 0; k < NUM_DPORTS; k++)
      if (dvalid_d[k]) data_d[k*MEM_W +: MEM_W] = mem[data_addr_i[k*IMEM_DEPTH +: IMEM_DEPTH]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      words_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      dvalid_q     <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      words_q      <= words_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      dvalid_q     <= dvalid_d;
      data_q       <= data_d;
    end
  end

  always_ff @(posedge clk)
    if (accept && rst_n) mem[cnt_q] <= load_data_i;

  assign load_ready_o   = ~run;
  assign boot_done_o    = run;
  assign words_loaded_o = words_q;
  assign inst_valid_o   = inst_valid_q;
  assign inst_o         = inst_q;
  assign data_valid_o   = dvalid_q;
  assign data_o         = data_q;
endmodule

// File: tb/tb_imem_mp.sv
// tb_imem_mp: scoreboard bench for imem_mp on a small 8-word array with a 16-bit instruction port.
module tb_imem_mp;
  localparam int D = 3, MW = 32, IW = 16, NP = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic load_valid_i = 1'b0, load_last_i = 1'b0, reload_i = 1'b0, inst_req_i = 1'b0;
  logic [MW-1:0] load_data_i = '0;
  logic [D-1:0] inst_addr_i = '0;
  logic [NP-1:0] data_req_i = '0;
  logic [NP*D-1:0] data_addr_i = '0;
  logic load_ready_o, boot_done_o, inst_valid_o;
  logic [D:0] words_loaded_o;
  logic [IW-1:0] inst_o;
  logic [NP-1:0] data_valid_o;
  logic [NP*MW-1:0] data_o;

  typedef struct {int kind; logic [31:0] val;} exp_t;
  exp_t sb[$];
  logic [31:0] model [8];
  int mcnt = 0, vecs = 0, errs = 0;

  imem_mp #(.IMEM_DEPTH(D), .MEM_W(MW), .INST_W(IW), .NUM_DPORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .load_data_i(load_data_i), .load_last_i(load_last_i), .reload_i(reload_i),
    .boot_done_o(boot_done_o), .words_loaded_o(words_loaded_o), .inst_req_i(inst_req_i),
    .inst_addr_i(inst_addr_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_valid_o(data_valid_o), .data_o(data_o));

  always #5 clk = ~clk;

  function automatic logic [32:0] got(int k);
    return k == 0 ? {inst_valid_o, 16'h0, inst_o} : k == 1 ? {data_valid_o[0], data_o[31:0]} : {data_valid_o[1], data_o[63:32]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_valid_i = 1'b0; load_last_i = 1'b0; reload_i = 1'b0; inst_req_i = 1'b0; data_req_i = '0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    load_valid_i = 1'b1; load_data_i = d; load_last_i = last;
    model[mcnt] = d;
    mcnt++;
    tick();
    load_valid_i = 1'b0; load_last_i = 1'b0;
  endtask

  // drives one read cycle; expected results are queued only when the DUT should answer
  task automatic req(input logic live, input logic i, input int ia, input logic r0, input int a0, input logic r1, input int a1);
    inst_req_i = i; inst_addr_i = D'(ia);
    data_req_i = {r1, r0}; data_addr_i = {D'(a1), D'(a0)};
    if (live && i) sb.push_back('{0, {16'h0, model[ia][15:0]}});
    if (live && r0) sb.push_back('{1, model[a0]});
    if (live && r1) sb.push_back('{2, model[a1]});
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (3) tick();
    vecs++;
    if ({load_ready_o, boot_done_o, words_loaded_o} !== {1'b1, 1'b0, 4'd0}) begin
      errs++; $display("FAIL reset_state: got rdy/done/words %b/%b/%0d want 1/0/0", load_ready_o, boot_done_o, words_loaded_o);
    end
    vecs++;
    if ({inst_valid_o, data_valid_o, inst_o, data_o} !== '0) begin
      errs++; $display("FAIL reset_outs: got iv=%b dv=%b inst=%h data=%h want all 0", inst_valid_o, data_valid_o, inst_o, data_o);
    end
    rst_n = 1'b1;
    tick();
    e.kind = 0;
  endtask

  task automatic test_load4();
    logic [31:0] v [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (load_ready_o !== 1'b1 || boot_done_o !== 1'b0) begin
        errs++; $display("FAIL load4_ready%0d: got rdy=%b done=%b want 1/0", i, load_ready_o, boot_done_o);
      end
      beat(v[i], i == 3);
    end
    vecs++;
    if ({load_ready_o, boot_done_o, words_loaded_o} !== {1'b0, 1'b1, 4'd4}) begin
      errs++; $display("FAIL load4_done: got rdy/done/words %b/%b/%0d want 0/1/4", load_ready_o, boot_done_o, words_loaded_o);
    end
  endtask

  task automatic test_reads();
    exp_t e;
    req(1, 1, 2, 1, 0, 1, 3);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front(); vecs++;
      if (got(e.kind) !== {1'b1, e.val}) begin errs++; $display("FAIL reads_port%0d: got %h want %h", e.kind, got(e.kind), {1'b1, e.val}); end
    end
    idle();
    tick();
    vecs++;
    if ({inst_valid_o, data_valid_o, inst_o, data_o} !== {3'b000, 16'h0033, 32'h44, 32'h11}) begin
      errs++; $display("FAIL reads_hold: got iv=%b dv=%b inst=%h data=%h want 0 00 0033 0000004400000011", inst_valid_o, data_valid_o, inst_o, data_o);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      req(1, 1, c, c != 1, 3 - c, 1, c + 1);
      tick();
      vecs++;
      if (data_valid_o[0] !== (c != 1)) begin errs++; $display("FAIL b2b_v0_%0d: got %b want %b", c, data_valid_o[0], c != 1); end
      while (sb.size() > 0) begin
        e = sb.pop_front(); vecs++;
        if (got(e.kind) !== {1'b1, e.val}) begin errs++; $display("FAIL b2b%0d_port%0d: got %h want %h", c, e.kind, got(e.kind), {1'b1, e.val}); end
      end
    end
    idle();
  endtask

  task automatic test_reload();
    exp_t e;
    reload_i = 1'b1;
    req(1, 1, 2, 0, 0, 0, 0);
    tick();
    idle();
    mcnt = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); vecs++;
      if (got(e.kind) !== {1'b1, e.val}) begin errs++; $display("FAIL reload_read%0d: got %h want %h", e.kind, got(e.kind), {1'b1, e.val}); end
    end
    vecs++;
    if ({load_ready_o, boot_done_o, words_loaded_o} !== {1'b1, 1'b0, 4'd4}) begin
      errs++; $display("FAIL reload_state: got rdy/done/words %b/%b/%0d want 1/0/4", load_ready_o, boot_done_o, words_loaded_o);
    end
  endtask

  task automatic test_gapped_load();
    exp_t e;
    beat(32'hA0, 1'b0);
    reload_i = 1'b1; load_data_i = 32'hBAD;
    req(0, 1, 0, 1, 0, 1, 1);
    tick();
    idle();
    vecs++;
    if ({inst_valid_o, data_valid_o, words_loaded_o, inst_o} !== {3'b000, 4'd1, 16'h0033}) begin
      errs++; $display("FAIL gap_noread: got iv=%b dv=%b words=%0d inst=%h want 0 00 1 0033", inst_valid_o, data_valid_o, words_loaded_o, inst_o);
    end
    beat(32'hB0, 1'b1);
    vecs++;
    if ({boot_done_o, words_loaded_o} !== {1'b1, 4'd2}) begin
      errs++; $display("FAIL gap_done: got done/words %b/%0d want 1/2", boot_done_o, words_loaded_o);
    end
    req(1, 1, 1, 1, 0, 1, 2);
    tick();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); vecs++;
      if (got(e.kind) !== {1'b1, e.val}) begin errs++; $display("FAIL gap_read%0d: got %h want %h", e.kind, got(e.kind), {1'b1, e.val}); end
    end
  endtask

  task automatic test_full();
    exp_t e;
    reload_i = 1'b1;
    tick();
    idle();
    mcnt = 0;
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (boot_done_o !== 1'b0) begin errs++; $display("FAIL full_early%0d: got done=%b want 0", i, boot_done_o); end
      beat(32'hC0DE_0000 + 32'(i * 32'h1111), 1'b0);
    end
    vecs++;
    if ({load_ready_o, boot_done_o, words_loaded_o} !== {1'b0, 1'b1, 4'd8}) begin
      errs++; $display("FAIL full_done: got rdy/done/words %b/%b/%0d want 0/1/8", load_ready_o, boot_done_o, words_loaded_o);
    end
    load_valid_i = 1'b1; load_data_i = 32'hFFFF_FFFF;
    tick();
    idle();
    req(1, 1, 7, 1, 0, 1, 7);
    tick();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); vecs++;
      if (got(e.kind) !== {1'b1, e.val}) begin errs++; $display("FAIL full_read%0d: got %h want %h", e.kind, got(e.kind), {1'b1, e.val}); end
    end
  endtask

  task automatic test_reset_midload();
    exp_t e;
    reload_i = 1'b1;
    tick();
    idle();
    mcnt = 0;
    beat(32'h55, 1'b0);
    beat(32'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({load_ready_o, boot_done_o, words_loaded_o, inst_valid_o, data_valid_o, inst_o, data_o} !== {1'b1, 1'b0, 4'd0, 3'b000, 16'h0, 64'h0}) begin
      errs++; $display("FAIL midrst_state: got rdy=%b done=%b words=%0d iv=%b dv=%b inst=%h data=%h want 1 0 0 0 00 0 0", load_ready_o, boot_done_o, words_loaded_o, inst_valid_o, data_valid_o, inst_o, data_o);
    end
    tick();
    rst_n = 1'b1;
    mcnt = 0;
    beat(32'h77, 1'b1);
    vecs++;
    if ({boot_done_o, words_loaded_o} !== {1'b1, 4'd1}) begin
      errs++; $display("FAIL midrst_done: got done/words %b/%0d want 1/1", boot_done_o, words_loaded_o);
    end
    req(1, 1, 2, 1, 0, 1, 1);
    tick();
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); vecs++;
      if (got(e.kind) !== {1'b1, e.val}) begin errs++; $display("FAIL midrst_read%0d: got %h want %h", e.kind, got(e.kind), {1'b1, e.val}); end
    end
  endtask

  initial begin
    test_reset();
    test_load4();
    test_reads();
    test_back_to_back();
    test_reload();
    test_gapped_load();
    test_full();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
